// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream and instruction-memory write bundle for inst_loader.
//
// Signals:
//   in_data   [7:0]       stream byte from the host
//   in_valid              in_data holds a byte
//   in_ready              loader can take a byte this cycle
//   im_we                 one-cycle instruction-memory write strobe
//   im_addr   [ADDR_W-1:0] word address qualified by im_we
//   im_wdata  [31:0]      word qualified by im_we
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready are
// both high. The host holds in_data stable while in_valid is high and the byte
// has not moved yet. in_ready depends only on loader state, never on in_valid.
//
// Modports: master = byte source / memory side, slave = the loader.
interface inst_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader for the instruction memory.
// Takes a framed byte stream (COUNT_HI, COUNT_LO, COUNT*4 payload bytes MSB
// first, CSUM), writes big-endian words to addresses 0.. and releases the
// datapath through lock only after the XOR checksum of the payload matches.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         inst_loader_if.slave: byte stream in, memory write port out
//   restart     one-cycle pulse, honored only in DONE or ERR
//   lock        processor run enable, high only in DONE
//   done        load complete with a good checksum
//   err         load aborted: bad checksum or count above DEPTH
//   dbg_state   current FSM state encoding
module inst_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_loader_if.slave       bus,
  input  logic               restart,
  output logic               lock,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    CNT_HI = 3'd0,
    CNT_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [15:0]   DEPTH16 = 16'(DEPTH);
  localparam logic [ADDR_W:0] W_ONE = 1;

  state_t            state, state_next;
  logic [15:0]       count;
  // One bit wider than the address so it can reach DEPTH after the last word.
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   widx_next;
  logic [1:0]        byte_idx;
  logic [7:0]        csum;
  logic [31:0]       asm_word;
  logic [31:0]       word_next;
  logic [15:0]       cnt_full;
  logic              last_word;
  logic              accept;
  logic              enter_cnt_hi;

  assign bus.in_ready = (state == CNT_HI) || (state == CNT_LO) ||
                        (state == DATA)   || (state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;
  assign lock         = (state == DONE);
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign dbg_state    = state;

  assign cnt_full     = {count[15:8], bus.in_data};
  assign widx_next    = word_idx + W_ONE;
  assign last_word    = ({{(15 - ADDR_W){1'b0}}, widx_next} == count);
  assign word_next    = {asm_word[23:0], bus.in_data};
  assign enter_cnt_hi = (state_next == CNT_HI) && (state != CNT_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CNT_HI;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CNT_HI: if (accept) state_next = CNT_LO;
      CNT_LO: begin
        if (accept) begin
          if (cnt_full > DEPTH16)      state_next = ERR;
          else if (cnt_full == 16'd0)  state_next = CSUM;
          else                         state_next = DATA;
        end
      end
      DATA:   if (accept && (byte_idx == 2'd3) && last_word) state_next = CSUM;
      CSUM: begin
        if (accept) state_next = (bus.in_data == csum) ? DONE : ERR;
      end
      DONE:   if (restart) state_next = CNT_HI;
      ERR:    if (restart) state_next = CNT_HI;
      default: state_next = CNT_HI;
    endcase
  end

  // Datapath: count capture, word assembly, running XOR and the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      asm_word     <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      if (enter_cnt_hi) begin
        count    <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end
      if (accept) begin
        case (state)
          CNT_HI: count[15:8] <= bus.in_data;
          CNT_LO: count[7:0]  <= bus.in_data;
          DATA: begin
            asm_word <= word_next;
            csum     <= csum ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= word_idx[ADDR_W-1:0];
              bus.im_wdata <= word_next;
              word_idx     <= widx_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed bench for inst_loader. Inputs are driven on the
// falling edge; outputs are sampled on the falling edge. A write monitor pops
// expected {addr, data} pairs from exp_q for every im_we pulse.
module tb_inst_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       lock, done, err;
  logic [2:0] dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [37:0] exp_q[$];
  logic [7:0]  frame[$];

  inst_loader_if #(.ADDR_W(6)) bus ();

  inst_loader #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .restart   (restart),
    .lock      (lock),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- write scoreboard ----------------
  logic [37:0] exp_e;
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {26'd0, bus.im_addr, bus.im_wdata}, 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("im_write", {26'd0, bus.im_addr, bus.im_wdata}, {26'd0, exp_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) send_byte(frame[i], $urandom_range(0, max_gap));
  endtask

  // Leaves the bench at the falling edge right after the final accepted byte.
  task automatic end_frame();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_nominal(input logic [7:0] cs);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0, cs};
    exp_q.push_back({6'd0, 32'h12345678});
    exp_q.push_back({6'd1, 32'h9ABCDEF0});
  endtask

  task automatic pulse_restart(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({tag, "_done"},  {63'd0, done},         64'd0);
    check({tag, "_lock"},  {63'd0, lock},         64'd0);
    check({tag, "_err"},   {63'd0, err},          64'd0);
    check({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"},   {63'd0, done},         64'd1);
    check({tag, "_lock"},   {63'd0, lock},         64'd1);
    check({tag, "_err"},    {63'd0, err},          64'd0);
    check({tag, "_ready"},  {63'd0, bus.in_ready}, 64'd0);
    check({tag, "_writes"}, 64'(exp_q.size()),     64'd0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
    check({tag, "_we"},    {63'd0, bus.im_we},    64'd0);
    check({tag, "_addr"},  {58'd0, bus.im_addr},  64'd0);
    check({tag, "_wdata"}, {32'd0, bus.im_wdata}, 64'd0);
    check({tag, "_lock"},  {63'd0, lock},         64'd0);
    check({tag, "_done"},  {63'd0, done},         64'd0);
    check({tag, "_err"},   {63'd0, err},          64'd0);
    check({tag, "_state"}, {61'd0, dbg_state},    64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  xs;
  logic [31:0] w;

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    expect_reset_outputs("reset");
    rst_n = 1'b1;

    // Nominal two-word load, back to back.
    set_nominal(8'h00);
    send_range(0, 10, 0);
    end_frame();
    expect_done("nominal");
    pulse_restart("rst_after_done");

    // Bad checksum: both words land, then ERR and no further acceptance.
    set_nominal(8'h89);
    send_range(0, 10, 0);
    end_frame();
    check("badcs_err",    {63'd0, err},          64'd1);
    check("badcs_lock",   {63'd0, lock},         64'd0);
    check("badcs_ready",  {63'd0, bus.in_ready}, 64'd0);
    check("badcs_writes", 64'(exp_q.size()),     64'd0);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("badcs_hold_err",   {63'd0, err},       64'd1);
    check("badcs_hold_state", {61'd0, dbg_state}, 64'd5);
    pulse_restart("rst_after_err");

    // Restart from ERR followed by a clean nominal frame.
    set_nominal(8'h00);
    send_range(0, 10, 0);
    end_frame();
    expect_done("after_err");
    pulse_restart("rst2");

    // Oversize count 0x0041 > 64: error right after COUNT_LO, no writes.
    frame = '{8'h00, 8'h41};
    send_range(0, 1, 0);
    end_frame();
    check("oversize_err",  {63'd0, err},          64'd1);
    check("oversize_lock", {63'd0, lock},         64'd0);
    check("oversize_done", {63'd0, done},         64'd0);
    check("oversize_ready", {63'd0, bus.in_ready}, 64'd0);
    pulse_restart("rst3");

    // Zero-length frame.
    frame = '{8'h00, 8'h00, 8'h00};
    send_range(0, 2, 0);
    end_frame();
    expect_done("zero_len");
    pulse_restart("rst4");

    // Nominal frame with random valid gaps.
    set_nominal(8'h00);
    send_range(0, 10, 3);
    end_frame();
    expect_done("stalled");
    pulse_restart("rst5");

    // Full DEPTH load: 64 words, last address 63.
    frame = '{8'h00, 8'h40};
    xs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), 8'(i + 3), 8'hA5, 8'(~i)};
      exp_q.push_back({6'(i), w});
      for (int k = 3; k >= 0; k--) begin
        frame.push_back(w[k*8 +: 8]);
        xs = xs ^ w[k*8 +: 8];
      end
    end
    frame.push_back(xs);
    send_range(0, frame.size() - 1, 0);
    end_frame();
    expect_done("full_depth");
    pulse_restart("rst6");

    // Restart pulse while in DATA is ignored.
    set_nominal(8'h00);
    send_range(0, 4, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("midrst_state", {61'd0, dbg_state},    64'd2);
    check("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
    send_range(5, 10, 0);
    end_frame();
    expect_done("midrst");
    pulse_restart("rst7");

    // Reset after 5 payload bytes: word 0 already written, then fresh load.
    exp_q.push_back({6'd0, 32'h12345678});
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_range(0, 6, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    expect_reset_outputs("midreset");
    check("midreset_writes", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_nominal(8'h00);
    send_range(0, 10, 0);
    end_frame();
    expect_done("after_reset");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
